// File: rtl/ctr_stream_scheduler.sv
// ctr_stream_scheduler: CTR-mode block sequencer with 2-deep keystream prefetch and ciphertext register.
// Define CTR_WRAP_GUARD_EN to reject descriptors whose counter would wrap (adds wrap_err).
module ctr_stream_scheduler #(
  parameter int CTR_WIDTH = 32,
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [127:0]         cfg_iv,
  input  logic [LEN_WIDTH-1:0] cfg_nblocks,
  input  logic                 pt_valid,
  output logic                 pt_ready,
  input  logic [127:0]         pt_data,
  output logic                 ct_valid,
  input  logic                 ct_ready,
  output logic [127:0]         ct_data,
  output logic                 ct_last,
  output logic                 eng_start,
  output logic [127:0]         eng_block,
  input  logic [127:0]         eng_keystream,
  input  logic                 eng_done,
  output logic                 busy,
`ifdef CTR_WRAP_GUARD_EN
  output logic                 wrap_err,
`endif
  output logic                 msg_done
);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state, state_nx;
  logic [127:0] iv, ks0, ks1;
  logic [LEN_WIDTH-1:0] nblocks, issued, consumed;
  logic [1:0] ks_count;
  logic in_flight, push, pop, cfg_hs, cfg_bad;
`ifdef CTR_WRAP_GUARD_EN
  localparam int SW = CTR_WIDTH + LEN_WIDTH + 1;
  logic [SW-1:0] wrap_sum;
  assign wrap_sum = SW'(cfg_iv[CTR_WIDTH-1:0]) + SW'(cfg_nblocks);
  assign cfg_bad = wrap_sum > (SW'(1) << CTR_WIDTH);
`else
  assign cfg_bad = 1'b0;
`endif
  assign cfg_ready = state == IDLE;
  assign busy = state != IDLE;
  assign msg_done = state == FIN;
  assign cfg_hs = cfg_valid && cfg_ready;
  assign eng_start = state == RUN && !in_flight && issued < nblocks && ks_count < 2'd2;
  // While a block is in flight, issued has already advanced; step back to keep eng_block stable.
  assign eng_block = {iv[127:CTR_WIDTH], iv[CTR_WIDTH-1:0] + CTR_WIDTH'(issued) - CTR_WIDTH'(in_flight)};
  assign push = eng_done && in_flight;
  assign pt_ready = state == RUN && ks_count != 2'd0 && (!ct_valid || ct_ready);
  assign pop = pt_valid && pt_ready;
  always_comb begin
    state_nx = state;
    if (cfg_hs && !cfg_bad) state_nx = cfg_nblocks != '0 ? RUN : FIN;
    else if (state == RUN && ct_valid && ct_ready && ct_last) state_nx = FIN;
    else if (state == FIN) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      iv <= '0;
      nblocks <= '0;
      issued <= '0;
      consumed <= '0;
      in_flight <= 1'b0;
      ks0 <= '0;
      ks1 <= '0;
      ks_count <= '0;
      ct_valid <= 1'b0;
      ct_data <= '0;
      ct_last <= 1'b0;
`ifdef CTR_WRAP_GUARD_EN
      wrap_err <= 1'b0;
`endif
    end else begin
      state <= state_nx;
`ifdef CTR_WRAP_GUARD_EN
      wrap_err <= cfg_hs && cfg_bad;
`endif
      if (cfg_hs && !cfg_bad) begin
        iv <= cfg_iv;
        nblocks <= cfg_nblocks;
        issued <= '0;
        consumed <= '0;
      end
      if (eng_start) begin
        in_flight <= 1'b1;
        issued <= issued + 1'b1;
      end else if (push) in_flight <= 1'b0;
      // Head is ks0; a push lands behind whatever survives this cycle's pop.
      if (pop) ks0 <= (push && ks_count == 2'd1) ? eng_keystream : ks1;
      else if (push && ks_count == 2'd0) ks0 <= eng_keystream;
      if (push && !pop && ks_count == 2'd1) ks1 <= eng_keystream;
      ks_count <= ks_count + 2'(push) - 2'(pop);
      if (pop) begin
        ct_data <= pt_data ^ ks0;
        ct_valid <= 1'b1;
        ct_last <= consumed == nblocks - 1'b1;
        consumed <= consumed + 1'b1;
      end else if (ct_ready) ct_valid <= 1'b0;
    end
  end
endmodule
